imm_decode_stage: RTL and testbench
===================================

# imm_decode_stage

Registered, parametrised RISC-V immediate decode stage with a valid/ready handshake and a two-entry skid buffer. It sits between fetch and execute. For each instruction it:
- classifies the immediate format;
- produces the sign- or zero-extended immediate at XLEN;
- computes `pc + imm` as the branch/jump/AUIPC target;
- flags instructions it does not recognise as illegal.

It sustains one instruction per cycle under backpressure and supports both RV32 and RV64 sizing.

## Interface
- XLEN, 32: datapath width. Legal values are 32 and 64 only.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous flush. Discards all buffered entries.
- in_valid  in  1  `in_inst`/`in_pc` are valid.
- in_ready  out  1  stage can accept an input this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  output fields are valid.
- out_ready  in  1  consumer accepts the output this cycle.
- out_imm  out  XLEN  extended immediate.
- out_fmt  out  3  format code: NONE=0, I=1, S=2, B=3, U=4, J=5, Z=6.
- out_target  out  XLEN  `in_pc + out_imm`, modulo 2^XLEN.
- out_illegal  out  1  unrecognised encoding.
- out_inst  out  32  pass-through of the instruction.

## Operation
- Decode is combinational on the input. Results are captured into the main register, or into the skid register when main is held.
- Any of the following gives NONE, imm 0, illegal=1:
  - `inst[1:0] != 2'b11`;
  - an opcode not listed below.
- Opcode-to-format mapping:
  - 0000011, 0010011, 1100111 → I.
  - 0011011 → I when XLEN=64; illegal when XLEN=32.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - 0110011 → NONE, not illegal.
  - 0111011 → NONE when XLEN=64; illegal when XLEN=32.
  - 1110011 → see Configuration.
- Bit layouts for I, S, B, U and J follow the RV base ISA.
  - All formats sign-extend from `inst[31]` to XLEN.
  - U therefore sign-extends bit 31 when XLEN=64.
  - B and J have bit 0 = 0.
- Z format: `imm = {(XLEN-5)'0, inst[19:15]}`, zero-extended.
- `out_target` uses the same registered `pc` and `imm`, truncated to XLEN, for every format.
- Handshake:
  - Input transfer occurs when `in_valid && in_ready`.
  - Output transfer occurs when `out_valid && out_ready`.
  - `out_*` fields are held stable while `out_valid && !out_ready`.
- Buffer states: EMPTY, ONE (main valid), TWO (main and skid valid).
  - EMPTY + accept → ONE.
  - ONE + accept, no drain → TWO.
  - ONE + drain, no accept → EMPTY.
  - ONE + accept + drain → ONE; main loads the new entry.
  - TWO + drain → ONE; skid moves to main. No input can be accepted in TWO.
- `in_ready = !skid_valid`. It is registered-derived, with no combinational path from `out_ready`.
- Order is strictly FIFO. Entries are never dropped or duplicated.
- Flush:
  - Next state is EMPTY.
  - Any input presented in the flush cycle is discarded, even if `in_ready` is high.
  - Flush wins over simultaneous accept and drain.

## Timing
- Latency: input accepted in cycle N → `out_valid` in cycle N+1.
- Throughput: 1 per cycle while `out_ready` is high.
- Reset values:
  - `out_valid=0`, `in_ready=1`;
  - `out_imm`, `out_target`, `out_inst` = 0;
  - `out_fmt=NONE`, `out_illegal=0`;
  - skid buffer empty.
- Reset asserted mid-operation clears both entries immediately (asynchronous). The first accept is possible in the first cycle after deassertion.
- `out_ready` may toggle freely.
- `out_valid` never deasserts without a transfer, except on flush or reset.

## Configuration
- Macro `IMM_DECODE_ZICSR_EN` controls opcode 1110011 (SYSTEM).
- Defined:
  - `funct3[2]=1` → Z format.
  - `funct3` = 001 or 010 or 011 → NONE, not illegal.
  - `funct3=000` → NONE, not illegal.
  - `funct3=100` → illegal.
- Undefined: SYSTEM with `funct3 != 000` → illegal; `funct3=000` → NONE. Code 6 is never produced.

## Structure
- Shared package `imm_decode_pkg`:
  - format enum `imm_fmt_e`;
  - opcode localparams (OP_LOAD, OP_IMM, OP_IMM32, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_SYSTEM, OP_REG, OP_REG32);
  - packed struct `imm_dec_t` {imm, fmt, target, illegal, inst}.
- One sub-module, `imm_decode_comb`:
  - purely combinational: inst, pc → `imm_dec_t`;
  - parametrised by XLEN.
- The top level holds the skid buffer and the handshake.

## Test plan
- XLEN=32, `out_ready=1`, pc=0x100, inst 0xFE000EE3 (beq -4) → next cycle fmt=B, imm=0xFFFFFFFC, target=0x000000FC.
- Back-to-back 0xFFF00093, 0x123450B7, 0x0080006F (pc 0x100) →
  - imm 0xFFFFFFFF (I);
  - imm 0x12345000 (U);
  - imm 8, target 0x108 (J);
  - on consecutive cycles.
- XLEN=64: inst 0x800000B7 → imm 0xFFFFFFFF80000000. 0x0000001B → I, not illegal; with XLEN=32 the same inst → illegal=1.
- Continuous input with `out_ready=0` for 3 cycles → `in_ready` falls after 2 accepts. After release, the outputs drain in order with no loss.
- Flush while in TWO with `in_valid=1` → next cycle `out_valid=0`, `in_ready=1`, input discarded.
- With `IMM_DECODE_ZICSR_EN`, inst 0x3057D073 (csrwi) → fmt=Z, imm=15. Without the macro → illegal=1. inst 0x00000013 with `inst[1:0]` forced to 00 → illegal=1.

Source files
------------

// File: rtl/imm_decode_pkg.sv
// Shared types and constants for the RISC-V immediate decode stage.
// Optional feature macro: IMM_DECODE_ZICSR_EN (decodes CSR immediate forms of SYSTEM).
package imm_decode_pkg;

   // Widest supported datapath; struct fields are sized for it and narrowed at the top level.
   localparam int unsigned XLEN_MAX = 64;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_Z    = 3'd6
   } imm_fmt_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_REG32  = 7'b0111011;

   // One decoded instruction; imm/target hold XLEN significant bits, zero-padded above.
   typedef struct packed {
      logic [XLEN_MAX-1:0] imm;
      imm_fmt_e            fmt;
      logic [XLEN_MAX-1:0] target;
      logic                illegal;
      logic [31:0]         inst;
   } imm_dec_t;

   // Sign-extend a 32-bit immediate to the widest datapath.
   function automatic logic [XLEN_MAX-1:0] sext32(input logic [31:0] v);
      return {{(XLEN_MAX-32){v[31]}}, v};
   endfunction

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational immediate decoder: instruction word + pc -> format, immediate, target, illegal.
// Optional feature macro: IMM_DECODE_ZICSR_EN (SYSTEM funct3[2]=1 decodes as Z format).
module imm_decode_comb
   import imm_decode_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [31:0]     inst,
   input  logic [XLEN-1:0] pc,
   output imm_dec_t        dec
);

   logic [31:0]         imm_i;
   logic [31:0]         imm_s;
   logic [31:0]         imm_b;
   logic [31:0]         imm_u;
   logic [31:0]         imm_j;
   imm_fmt_e            fmt;
   logic                illegal;
   logic [XLEN_MAX-1:0] imm64;
   logic [XLEN-1:0]     imm_x;
   logic [XLEN-1:0]     target;
   logic                unused_imm;

   assign imm_i = {{20{inst[31]}}, inst[31:20]};
   assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u = {inst[31:12], 12'h000};
   assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

   // Classify the opcode into an immediate format and flag unknown encodings.
   always_comb begin
      fmt     = FMT_NONE;
      illegal = 1'b0;
      if (inst[1:0] != 2'b11) begin
         illegal = 1'b1;
      end else begin
         case (inst[6:0])
            OP_LOAD, OP_IMM, OP_JALR: fmt = FMT_I;
            OP_IMM32: begin
               if (XLEN == 64) fmt = FMT_I;
               else            illegal = 1'b1;
            end
            OP_STORE:        fmt = FMT_S;
            OP_BRANCH:       fmt = FMT_B;
            OP_LUI, OP_AUIPC: fmt = FMT_U;
            OP_JAL:          fmt = FMT_J;
            OP_REG:          fmt = FMT_NONE;
            OP_REG32: begin
               if (XLEN != 64) illegal = 1'b1;
            end
            OP_SYSTEM: begin
`ifdef IMM_DECODE_ZICSR_EN
               if (inst[14:12] == 3'b100) illegal = 1'b1;
               else if (inst[14])         fmt = FMT_Z;
`else
               if (inst[14:12] != 3'b000) illegal = 1'b1;
`endif
            end
            default: illegal = 1'b1;
         endcase
      end
   end

   // Select the extended immediate for the decoded format; NONE and illegal give zero.
   always_comb begin
      case (fmt)
         FMT_I:   imm64 = sext32(imm_i);
         FMT_S:   imm64 = sext32(imm_s);
         FMT_B:   imm64 = sext32(imm_b);
         FMT_U:   imm64 = sext32(imm_u);
         FMT_J:   imm64 = sext32(imm_j);
         FMT_Z:   imm64 = {{(XLEN_MAX-5){1'b0}}, inst[19:15]};
         default: imm64 = '0;
      endcase
   end

   assign imm_x      = imm64[XLEN-1:0];
   assign target     = pc + imm_x;
   assign unused_imm = ^imm64;

   // Pack the decode result; fields narrower than the widest datapath are zero-padded.
   always_comb begin
      dec         = '0;
      dec.imm     = XLEN_MAX'(imm_x);
      dec.fmt     = fmt;
      dec.target  = XLEN_MAX'(target);
      dec.illegal = illegal;
      dec.inst    = inst;
   end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate decode stage with valid/ready handshake and a two-entry skid buffer.
// Optional feature macro: IMM_DECODE_ZICSR_EN (passed through to imm_decode_comb).
module imm_decode_stage
   import imm_decode_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic [XLEN-1:0] out_target,
   output logic            out_illegal,
   output logic [31:0]     out_inst
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   logic [1:0] state;
   logic [1:0] state_nxt;
   imm_dec_t   dec;
   imm_dec_t   main_q;
   imm_dec_t   skid_q;
   logic       accept;
   logic       drain;
   logic       load_main;
   logic       main_from_skid;
   logic       load_skid;
   logic       unused_hi;

   imm_decode_comb #(
      .XLEN (XLEN)
   ) u_comb (
      .inst (in_inst),
      .pc   (in_pc),
      .dec  (dec)
   );

   // Both handshake outputs come straight from the state register.
   assign in_ready  = (state != ST_TWO);
   assign out_valid = (state != ST_EMPTY);
   assign accept    = in_valid && in_ready && !flush;
   assign drain     = out_valid && out_ready;

   // Next occupancy and register load enables; flush overrides any transfer.
   always_comb begin
      state_nxt      = state;
      load_main      = 1'b0;
      main_from_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_nxt = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  load_main = 1'b1;
                  state_nxt = ST_ONE;
               end
            end
            ST_ONE: begin
               case ({accept, drain})
                  2'b10: begin
                     load_skid = 1'b1;
                     state_nxt = ST_TWO;
                  end
                  2'b01: state_nxt = ST_EMPTY;
                  2'b11: load_main = 1'b1;
                  default: state_nxt = ST_ONE;
               endcase
            end
            ST_TWO: begin
               if (drain) begin
                  main_from_skid = 1'b1;
                  state_nxt      = ST_ONE;
               end
            end
            default: state_nxt = ST_EMPTY;
         endcase
      end
   end

   // Occupancy register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_EMPTY;
      else     state <= state_nxt;
   end

   // Main (output) and skid entries; main only changes on a transfer so outputs hold under stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main)           main_q <= dec;
         else if (main_from_skid) main_q <= skid_q;
         if (load_skid)           skid_q <= dec;
      end
   end

   assign out_imm     = main_q.imm[XLEN-1:0];
   assign out_fmt     = main_q.fmt;
   assign out_target  = main_q.target[XLEN-1:0];
   assign out_illegal = main_q.illegal;
   assign out_inst    = main_q.inst;
   assign unused_hi   = ^{main_q.imm, main_q.target};

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench: an RV32 and an RV64 instance share stimulus; table vectors,
// hand-written handshake sequences and a randomized run against a reference model.
module tb_imm_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_inst;
   logic [63:0] in_pc;

   logic        in_ready_a, out_valid_a, out_illegal_a;
   logic [31:0] out_imm_a, out_target_a, out_inst_a;
   logic [2:0]  out_fmt_a;
   logic        in_ready_b, out_valid_b, out_illegal_b;
   logic [63:0] out_imm_b, out_target_b;
   logic [31:0] out_inst_b;
   logic [2:0]  out_fmt_b;

   always #5 clk = ~clk;

   imm_decode_stage #(.XLEN(32)) dut_a (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(out_valid_a), .out_ready(out_ready),
      .out_imm(out_imm_a), .out_fmt(out_fmt_a), .out_target(out_target_a),
      .out_illegal(out_illegal_a), .out_inst(out_inst_a)
   );

   imm_decode_stage #(.XLEN(64)) dut_b (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid_b), .out_ready(out_ready),
      .out_imm(out_imm_b), .out_fmt(out_fmt_b), .out_target(out_target_b),
      .out_illegal(out_illegal_b), .out_inst(out_inst_b)
   );

   typedef struct {
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic [63:0] tgt;
      logic        ill;
      logic [31:0] inst;
   } exp_t;

   typedef struct {
      logic [31:0] inst;
      logic [63:0] pc;
      logic [31:0] imm32, tgt32;
      logic [2:0]  fmt32;
      logic        ill32;
      logic [63:0] imm64, tgt64;
      logic [2:0]  fmt64;
      logic        ill64;
   } vec_t;

   int   vecs = 0;
   int   errs = 0;
   vec_t tbl[$];
   exp_t qa[$];
   exp_t qb[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference decode straight from the ISA immediate layouts, using signed arithmetic.
   function automatic exp_t model(input logic [31:0] inst, input logic [63:0] pc, input int xlen);
      exp_t   e;
      longint s, sg, t, imm;
      logic [63:0] mask;
      logic [2:0]  f3;
      s    = longint'($signed(inst));
      sg   = s >>> 31;
      f3   = inst[14:12];
      imm  = 0;
      e.fmt = 3'd0;
      e.ill = 1'b0;
      e.inst = inst;
      if (inst[1:0] != 2'b11) e.ill = 1'b1;
      else begin
         case (inst[6:0])
            7'h03, 7'h13, 7'h67: begin e.fmt = 3'd1; imm = s >>> 20; end
            7'h1B: begin
               if (xlen == 64) begin e.fmt = 3'd1; imm = s >>> 20; end
               else e.ill = 1'b1;
            end
            7'h23: begin e.fmt = 3'd2; t = s >>> 25; imm = (t << 5) | 64'(inst[11:7]); end
            7'h63: begin
               e.fmt = 3'd3;
               imm = (sg << 12) | (64'(inst[7]) << 11) | (64'(inst[30:25]) << 5) | (64'(inst[11:8]) << 1);
            end
            7'h37, 7'h17: begin e.fmt = 3'd4; imm = s & 64'hFFFF_FFFF_FFFF_F000; end
            7'h6F: begin
               e.fmt = 3'd5;
               imm = (sg << 20) | (64'(inst[19:12]) << 12) | (64'(inst[20]) << 11) | (64'(inst[30:21]) << 1);
            end
            7'h33: e.fmt = 3'd0;
            7'h3B: if (xlen != 64) e.ill = 1'b1;
            7'h73: begin
`ifdef IMM_DECODE_ZICSR_EN
               if (f3 == 3'd4) e.ill = 1'b1;
               else if (f3 >= 3'd5) begin e.fmt = 3'd6; imm = 64'(inst[19:15]); end
`else
               if (f3 != 3'd0) e.ill = 1'b1;
`endif
            end
            default: e.ill = 1'b1;
         endcase
      end
      mask  = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      e.imm = imm & mask;
      e.tgt = (pc + imm) & mask;
      return e;
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 15))
         0:  w[6:0] = 7'h03;
         1:  w[6:0] = 7'h13;
         2:  w[6:0] = 7'h67;
         3:  w[6:0] = 7'h1B;
         4:  w[6:0] = 7'h23;
         5:  w[6:0] = 7'h63;
         6:  w[6:0] = 7'h37;
         7:  w[6:0] = 7'h17;
         8:  w[6:0] = 7'h6F;
         9:  w[6:0] = 7'h33;
         10: w[6:0] = 7'h3B;
         11: w[6:0] = 7'h73;
         12: w[6:0] = 7'h73;
         default: ;
      endcase
      return w;
   endfunction

   task automatic add_vec(input logic [31:0] inst, input logic [63:0] pc,
                          input logic [31:0] imm32, input logic [31:0] tgt32,
                          input logic [2:0] fmt32, input logic ill32,
                          input logic [63:0] imm64, input logic [63:0] tgt64,
                          input logic [2:0] fmt64, input logic ill64);
      vec_t v;
      v = '{inst, pc, imm32, tgt32, fmt32, ill32, imm64, tgt64, fmt64, ill64};
      tbl.push_back(v);
   endtask

   task automatic check_vec(input int i);
      vec_t v;
      v = tbl[i];
      chk($sformatf("tbl%0d_valid32", i), 64'(out_valid_a), 64'd1);
      chk($sformatf("tbl%0d_imm32", i), 64'(out_imm_a), 64'(v.imm32));
      chk($sformatf("tbl%0d_fmt32", i), 64'(out_fmt_a), 64'(v.fmt32));
      chk($sformatf("tbl%0d_tgt32", i), 64'(out_target_a), 64'(v.tgt32));
      chk($sformatf("tbl%0d_ill32", i), 64'(out_illegal_a), 64'(v.ill32));
      chk($sformatf("tbl%0d_inst32", i), 64'(out_inst_a), 64'(v.inst));
      chk($sformatf("tbl%0d_valid64", i), 64'(out_valid_b), 64'd1);
      chk($sformatf("tbl%0d_imm64", i), out_imm_b, v.imm64);
      chk($sformatf("tbl%0d_fmt64", i), 64'(out_fmt_b), 64'(v.fmt64));
      chk($sformatf("tbl%0d_tgt64", i), out_target_b, v.tgt64);
      chk($sformatf("tbl%0d_ill64", i), 64'(out_illegal_b), 64'(v.ill64));
   endtask

   task automatic check_hs(input string name, input logic ov, input logic ir);
      chk({name, "_ovalid32"}, 64'(out_valid_a), 64'(ov));
      chk({name, "_iready32"}, 64'(in_ready_a), 64'(ir));
      chk({name, "_ovalid64"}, 64'(out_valid_b), 64'(ov));
      chk({name, "_iready64"}, 64'(in_ready_b), 64'(ir));
   endtask

   task automatic check_exp(input string name, input exp_t ea, input exp_t eb);
      chk({name, "_imm32"}, 64'(out_imm_a), ea.imm);
      chk({name, "_fmt32"}, 64'(out_fmt_a), 64'(ea.fmt));
      chk({name, "_tgt32"}, 64'(out_target_a), ea.tgt);
      chk({name, "_ill32"}, 64'(out_illegal_a), 64'(ea.ill));
      chk({name, "_inst32"}, 64'(out_inst_a), 64'(ea.inst));
      chk({name, "_imm64"}, out_imm_b, eb.imm);
      chk({name, "_fmt64"}, 64'(out_fmt_b), 64'(eb.fmt));
      chk({name, "_tgt64"}, out_target_b, eb.tgt);
      chk({name, "_ill64"}, 64'(out_illegal_b), 64'(eb.ill));
      chk({name, "_inst64"}, 64'(out_inst_b), 64'(eb.inst));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0] ia, ib, ic;
      bit          acc, drn;

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_inst = '0; in_pc = '0;
      ia = 32'h0010_0093; ib = 32'h0020_0113; ic = 32'h0030_0193;

      // Hand-computed decode vectors (pc 0x100 unless noted).
      add_vec(32'hFE00_0EE3, 64'h100, 32'hFFFF_FFFC, 32'h0000_00FC, 3'd3, 1'b0,
              64'hFFFF_FFFF_FFFF_FFFC, 64'h0FC, 3'd3, 1'b0);
      add_vec(32'hFFF0_0093, 64'h100, 32'hFFFF_FFFF, 32'h0000_00FF, 3'd1, 1'b0,
              64'hFFFF_FFFF_FFFF_FFFF, 64'h0FF, 3'd1, 1'b0);
      add_vec(32'h1234_50B7, 64'h100, 32'h1234_5000, 32'h1234_5100, 3'd4, 1'b0,
              64'h1234_5000, 64'h1234_5100, 3'd4, 1'b0);
      add_vec(32'h0080_006F, 64'h100, 32'h8, 32'h108, 3'd5, 1'b0, 64'h8, 64'h108, 3'd5, 1'b0);
      add_vec(32'h8000_00B7, 64'h100, 32'h8000_0000, 32'h8000_0100, 3'd4, 1'b0,
              64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0100, 3'd4, 1'b0);
      add_vec(32'h0000_001B, 64'h100, 32'h0, 32'h100, 3'd0, 1'b1, 64'h0, 64'h100, 3'd1, 1'b0);
      add_vec(32'h0000_0010, 64'h100, 32'h0, 32'h100, 3'd0, 1'b1, 64'h0, 64'h100, 3'd0, 1'b1);
      add_vec(32'h0000_0013, 64'h100, 32'h0, 32'h100, 3'd1, 1'b0, 64'h0, 64'h100, 3'd1, 1'b0);
      add_vec(32'hFE11_2E23, 64'h100, 32'hFFFF_FFFC, 32'h0000_00FC, 3'd2, 1'b0,
              64'hFFFF_FFFF_FFFF_FFFC, 64'h0FC, 3'd2, 1'b0);
      add_vec(32'h0000_0033, 64'h100, 32'h0, 32'h100, 3'd0, 1'b0, 64'h0, 64'h100, 3'd0, 1'b0);
      add_vec(32'h0000_003B, 64'h100, 32'h0, 32'h100, 3'd0, 1'b1, 64'h0, 64'h100, 3'd0, 1'b0);
      add_vec(32'h0000_007F, 64'h100, 32'h0, 32'h100, 3'd0, 1'b1, 64'h0, 64'h100, 3'd0, 1'b1);
      add_vec(32'h0000_0073, 64'h100, 32'h0, 32'h100, 3'd0, 1'b0, 64'h0, 64'h100, 3'd0, 1'b0);
      add_vec(32'h0000_4073, 64'h100, 32'h0, 32'h100, 3'd0, 1'b1, 64'h0, 64'h100, 3'd0, 1'b1);
`ifdef IMM_DECODE_ZICSR_EN
      add_vec(32'h3057_D073, 64'h100, 32'hF, 32'h10F, 3'd6, 1'b0, 64'hF, 64'h10F, 3'd6, 1'b0);
`else
      add_vec(32'h3057_D073, 64'h100, 32'h0, 32'h100, 3'd0, 1'b1, 64'h0, 64'h100, 3'd0, 1'b1);
`endif
      add_vec(32'h0080_006F, 64'h0000_0000_FFFF_FFFC, 32'h8, 32'h4, 3'd5, 1'b0,
              64'h8, 64'h1_0000_0004, 3'd5, 1'b0);

      // Reset state.
      tick();
      check_hs("reset", 1'b0, 1'b1);
      check_exp("reset", '{64'h0, 3'd0, 64'h0, 1'b0, 32'h0}, '{64'h0, 3'd0, 64'h0, 1'b0, 32'h0});
      rst = 1'b0;

      // Table vectors streamed back to back; each result appears one cycle after its input.
      for (int i = 0; i <= tbl.size(); i++) begin
         if (i > 0) check_vec(i - 1);
         if (i < tbl.size()) begin
            in_valid = 1'b1;
            in_inst  = tbl[i].inst;
            in_pc    = tbl[i].pc;
         end else begin
            in_valid = 1'b0;
         end
         tick();
      end
      check_hs("tbl_end", 1'b0, 1'b1);

      // Backpressure: three stalled cycles of continuous input, then drain in order.
      in_pc = 64'h200; out_ready = 1'b0; in_valid = 1'b1;
      in_inst = ia; tick();
      check_hs("bp1", 1'b1, 1'b1);
      in_inst = ib; tick();
      check_hs("bp2", 1'b1, 1'b0);
      chk("bp2_inst", 64'(out_inst_a), 64'(ia));
      in_inst = ic; tick();
      check_hs("bp3", 1'b1, 1'b0);
      chk("bp3_inst_hold", 64'(out_inst_b), 64'(ia));
      in_valid = 1'b0; out_ready = 1'b1; tick();
      check_hs("bp_drain1", 1'b1, 1'b1);
      check_exp("bp_drain1", model(ib, 64'h200, 32), model(ib, 64'h200, 64));
      tick();
      check_hs("bp_drain2", 1'b0, 1'b1);

      // Flush in TWO with input presented.
      out_ready = 1'b0; in_valid = 1'b1;
      in_inst = ia; tick();
      in_inst = ib; tick();
      check_hs("fl_two_pre", 1'b1, 1'b0);
      flush = 1'b1; in_inst = ic; tick();
      flush = 1'b0; in_valid = 1'b0;
      check_hs("fl_two", 1'b0, 1'b1);
      tick();
      check_hs("fl_two_after", 1'b0, 1'b1);

      // Flush in ONE with in_ready high and out_ready high: input and entry discarded.
      in_valid = 1'b1; in_inst = ia; tick();
      flush = 1'b1; out_ready = 1'b1; in_inst = ic; tick();
      flush = 1'b0; in_valid = 1'b0;
      check_hs("fl_one", 1'b0, 1'b1);
      tick();
      check_hs("fl_one_after", 1'b0, 1'b1);

      // Asynchronous reset mid-operation, then accept in the first cycle after release.
      out_ready = 1'b0; in_valid = 1'b1;
      in_inst = ia; tick();
      in_inst = ib; tick();
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check_hs("arst", 1'b0, 1'b1);
      chk("arst_inst", 64'(out_inst_b), 64'h0);
      tick();
      rst = 1'b0; in_valid = 1'b1; in_inst = ic; out_ready = 1'b1; tick();
      in_valid = 1'b0;
      check_hs("arst_first", 1'b1, 1'b1);
      check_exp("arst_first", model(ic, 64'h200, 32), model(ic, 64'h200, 64));
      tick();
      check_hs("arst_empty", 1'b0, 1'b1);

      // Randomized traffic against the occupancy/FIFO reference model.
      do_reset();
      qa.delete(); qb.delete();
      for (int c = 0; c < 3000; c++) begin
         chk("rnd_ovalid32", 64'(out_valid_a), 64'(qa.size() > 0));
         chk("rnd_iready32", 64'(in_ready_a), 64'(qa.size() < 2));
         chk("rnd_ovalid64", 64'(out_valid_b), 64'(qb.size() > 0));
         chk("rnd_iready64", 64'(in_ready_b), 64'(qb.size() < 2));
         if (qa.size() > 0 && qb.size() > 0) check_exp("rnd", qa[0], qb[0]);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         in_inst   = rand_inst();
         in_pc     = {$urandom, $urandom};
         acc = in_valid && (qa.size() < 2) && !flush;
         drn = (qa.size() > 0) && out_ready;
         tick();
         if (flush) begin
            qa.delete();
            qb.delete();
         end else begin
            if (drn) begin
               void'(qa.pop_front());
               void'(qb.pop_front());
            end
            if (acc) begin
               qa.push_back(model(in_inst, 64'(in_pc[31:0]), 32));
               qb.push_back(model(in_inst, in_pc, 64));
            end
         end
      end
      flush = 1'b0; in_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
